// File: rtl/satd_pipe_nxn_if.sv
// ---------------------------------------------------------------------------
// satd_pipe_nxn_if
// Handshake bundle between the pixel fetch unit (master), the SATD pipe
// (slave) and the mode-decision cost comparator that consumes the result.
//
// Signals:
//   in_valid  master->slave  row beat valid
//   in_ready  slave->master  pipe can accept a row
//   org_row   master->slave  WIDTH*N original row, pixel i at [i*WIDTH +: WIDTH]
//   cur_row   master->slave  WIDTH*N candidate row, same packing
//   out_valid slave->master  satd holds a finished block result
//   out_ready master->slave  consumer takes the result
//   satd      slave->master  SUM_W bit SATD of the last completed block
//   busy      slave->master  pipe is in its column or result phase
// ---------------------------------------------------------------------------
interface satd_pipe_nxn_if #(
  parameter int WIDTH = 8,
  parameter int N     = 8
);
  localparam int LOG2N = $clog2(N);
  localparam int SUM_W = WIDTH + 1 + 4 * LOG2N;

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH*N-1:0]   org_row;
  logic [WIDTH*N-1:0]   cur_row;
  logic                 out_valid;
  logic                 out_ready;
  logic [SUM_W-1:0]     satd;
  logic                 busy;

  modport master (
    output in_valid, org_row, cur_row, out_ready,
    input  in_ready, out_valid, satd, busy
  );

  modport slave (
    input  in_valid, org_row, cur_row, out_ready,
    output in_ready, out_valid, satd, busy
  );
endinterface

// File: rtl/satd_pipe_nxn.sv
// ---------------------------------------------------------------------------
// satd_pipe_nxn
// NxN SATD datapath. Each accepted row beat forms signed ORG-CUR differences,
// runs a horizontal Hadamard butterfly and stores the coefficients in a
// transpose buffer. Once N rows are in, one buffer column per cycle goes
// through a vertical Hadamard and the absolute coefficients are accumulated.
// The block SATD is then held on a valid/ready output until taken.
//
// Parameters:
//   WIDTH  bits per unsigned pixel sample
//   N      block size, 4 or 8 only
//   LOG2N / SUM_W are derived internally and cannot be overridden
//
// Ports:
//   clk  clock
//   rst  synchronous active-high reset, discards any partial block
//   bus  satd_pipe_nxn_if.slave (row input, result output, busy)
//
// Optional feature macro: SATD_NORM_EN
//   defined   -> satd = (acc + 2^(k-1)) >> k, k=1 for N=4, k=2 for N=8
//   undefined -> satd = raw accumulated absolute sum
// ---------------------------------------------------------------------------
module satd_pipe_nxn #(
  parameter int WIDTH = 8,
  parameter int N     = 8
) (
  input logic            clk,
  input logic            rst,
  satd_pipe_nxn_if.slave bus
);

  localparam int LOG2N = $clog2(N);
  localparam int SUM_W = WIDTH + 1 + 4 * LOG2N;
  localparam int DW    = WIDTH + 1;
  localparam int RW    = DW + LOG2N;
  localparam int VW    = RW + LOG2N;
  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

  if (N != 4 && N != 8) begin : g_bad_n
    $error("satd_pipe_nxn: N must be 4 or 8");
  end

  typedef enum logic [1:0] {LOAD, VERT, DONE} state_t;

  state_t            state;
  logic [LOG2N-1:0]  row_cnt;
  logic [LOG2N-1:0]  col_cnt;
  logic [SUM_W-1:0]  acc;
  logic [SUM_W-1:0]  satd_q;
  logic              out_valid_q;
  logic              in_ready_q;
  logic              busy_q;

  logic signed [RW-1:0] tbuf     [N][N];
  logic signed [RW-1:0] row_coef [N];
  logic [SUM_W-1:0]     col_sum;
  logic [SUM_W-1:0]     acc_next;
  logic [SUM_W-1:0]     satd_next;

  // Horizontal transform of the incoming row. Every stage is carried at the
  // final row width; sign extension up front keeps the arithmetic exact.
  // Pairing i with i^step yields the natural-order Hadamard.
  always_comb begin : h_row
    logic signed [DW-1:0] d;
    logic signed [RW-1:0] a [N];
    logic signed [RW-1:0] b [N];
    for (int i = 0; i < N; i++) begin
      d    = $signed({1'b0, bus.org_row[i*WIDTH +: WIDTH]})
           - $signed({1'b0, bus.cur_row[i*WIDTH +: WIDTH]});
      a[i] = RW'(d);
    end
    b = a;
    for (int s = 0; s < LOG2N; s++) begin
      for (int i = 0; i < N; i++) begin
        if ((i & (1 << s)) == 0) b[i] = a[i] + a[i ^ (1 << s)];
        else                     b[i] = a[i ^ (1 << s)] - a[i];
      end
      a = b;
    end
    row_coef = a;
  end

  // Vertical transform of buffer column col_cnt, followed by the sum of
  // absolute coefficients for that column.
  always_comb begin : h_col
    logic signed [VW-1:0] a [N];
    logic signed [VW-1:0] b [N];
    for (int i = 0; i < N; i++) a[i] = VW'(tbuf[i][col_cnt]);
    b = a;
    for (int s = 0; s < LOG2N; s++) begin
      for (int i = 0; i < N; i++) begin
        if ((i & (1 << s)) == 0) b[i] = a[i] + a[i ^ (1 << s)];
        else                     b[i] = a[i ^ (1 << s)] - a[i];
      end
      a = b;
    end
    col_sum = '0;
    for (int i = 0; i < N; i++) begin
      col_sum = col_sum + SUM_W'((a[i] < 0) ? -a[i] : a[i]);
    end
  end

  assign acc_next = acc + col_sum;

`ifdef SATD_NORM_EN
  localparam int K = (N == 4) ? 1 : 2;
  assign satd_next = (acc_next + SUM_W'(1 << (K - 1))) >> K;
`else
  assign satd_next = acc_next;
`endif

  // Transpose buffer: rows are written only while accepting beats; its
  // contents after reset are irrelevant because a block always fills it.
  always_ff @(posedge clk) begin
    if (bus.in_valid && in_ready_q) tbuf[row_cnt] <= row_coef;
  end

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LOAD;
      row_cnt     <= '0;
      col_cnt     <= '0;
      acc         <= '0;
      satd_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      unique case (state)
        LOAD: begin
          if (bus.in_valid) begin
            if (row_cnt == LAST) begin
              row_cnt    <= '0;
              acc        <= '0;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
              state      <= VERT;
            end else begin
              row_cnt <= row_cnt + 1'b1;
            end
          end
        end
        VERT: begin
          acc <= acc_next;
          if (col_cnt == LAST) begin
            col_cnt     <= '0;
            satd_q      <= satd_next;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            col_cnt <= col_cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state       <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.satd      = satd_q;
  assign bus.busy      = busy_q;

endmodule

// File: doc/satd_pipe_nxn.md
Name: satd_pipe_nxn

Overview:
- Parametrised successor to the single-row SATD datapath.
- Accepts one row of ORG/CUR pixels per handshake beat and forms signed differences.
- Applies a horizontal Hadamard transform per row, stores the rows in an NxN transpose buffer, then applies a vertical Hadamard one column per cycle.
- Accumulates absolute coefficients and presents one SATD per NxN block on a valid/ready output; sits between the pixel fetch unit and the mode-decision cost comparator.

Parameters:
- WIDTH, 8, bits per unsigned pixel sample.
- N, 8, block size and samples per row; legal values 4 or 8 only (elaboration error otherwise).
- LOG2N, $clog2(N), derived; not to be overridden.
- SUM_W, WIDTH+1+4*LOG2N, derived width of the raw SATD accumulator.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  row beat valid.
- in_ready  out  1  block can accept a row.
- org_row  in  WIDTH*N  original row; pixel i at [i*WIDTH +: WIDTH], unsigned.
- cur_row  in  WIDTH*N  candidate row, same packing.
- out_valid  out  1  satd holds a finished block result.
- out_ready  in  1  consumer takes the result.
- satd  out  SUM_W  SATD of the last completed block.
- busy  out  1  high in VERT or DONE.

Behaviour:
- Clocking: clk; reset rst, synchronous, active-high.
- Reset values: state=LOAD, row_cnt=0, col_cnt=0, acc=0, satd=0, out_valid=0, in_ready=1, busy=0; transpose buffer contents don't-care.
- Reset at any point, including mid-LOAD or mid-VERT, discards the partial block.
- States: LOAD, VERT, DONE.
- LOAD:
  - in_ready=1.
  - A beat is in_valid&in_ready at a rising edge.
  - Per beat: d[i]=org[i]-cur[i], signed WIDTH+1 bits.
  - Combinational N-point Hadamard butterfly (LOG2N stages, +1 bit per stage) gives WIDTH+1+LOG2N bit coefficients.
  - Coefficients are written to buffer row row_cnt, then row_cnt increments.
  - When the beat with row_cnt==N-1 is accepted: row_cnt->0, acc->0, state->VERT.
  - in_valid low inserts gaps with no state change.
- VERT:
  - in_ready=0; beats are ignored.
  - Each cycle, column col_cnt is read from the buffer and passed through a combinational N-point Hadamard (WIDTH+1+2*LOG2N bits).
  - acc += sum of |coef| over the N outputs.
  - After col_cnt==N-1 is processed: col_cnt->0, satd<=final value, out_valid<=1, state->DONE.
  - out_valid is therefore observed high exactly N rising edges after the edge that accepted the last row.
- DONE:
  - out_valid=1 and satd are held stable while out_ready=0.
  - out_valid&out_ready at an edge: out_valid->0, state->LOAD; in_ready=1 from the next cycle.
  - No overlap with the next block's first row.
- Arithmetic:
  - No saturation anywhere; widths as stated are overflow-free.
  - Butterfly output ordering (natural vs sequency) is free, because the absolute sum is invariant to coefficient ordering and sign.
- busy = (state!=LOAD).

Optional Feature:
- Macro: SATD_NORM_EN.
- Defined: satd = (acc + (1<<(k-1))) >> k, with k=1 for N=4 and k=2 for N=8 (HEVC-style normalisation). satd keeps width SUM_W with upper bits zero.
- Undefined: satd = raw acc.
- Latency and handshake are identical in both cases.

Test Plan:
- N=8: org_row=cur_row=all 0x5A for 8 beats -> out_valid 8 edges after the last beat, satd=0.
- N=8: org all 255, cur all 0 -> raw satd=16320; with SATD_NORM_EN satd=4080.
- N=4: org all 255, cur all 0 -> raw satd=4080; with SATD_NORM_EN satd=2040.
- N=8: org[row0][0]=10, all other pixels 0, cur all 0 -> raw satd=640 (64 coefficients of |10|); normalised satd=160.
- Handshake: random in_valid gaps during LOAD plus out_ready held low 5 cycles in DONE -> satd stable, in_ready=0 throughout VERT/DONE, block result unchanged vs the gap-free run.
- Reset asserted in the 3rd VERT cycle -> next cycle out_valid=0, in_ready=1, busy=0; the following full block (constant 255/0) yields satd=16320.
